// File: rtl/dp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dp_ctrl_pkg
// Shared definitions for the data-path pipeline controllers:
//   state_e      - controller FSM state encoding
//   MODE_*       - triple-buffer mode values (which buffer each stage owns)
//   stage_e      - stage index used to address per-stage vectors
//   next_mode()  - buffer rotation order 0 -> 1 -> 2 -> 0
// ---------------------------------------------------------------------------
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SWAP   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Buffer mode: which buffer is owned by AXI / NTT / MADD.
  localparam logic [1:0] MODE_AXI_NTT_MADD = 2'd0;
  localparam logic [1:0] MODE_NTT_MADD_AXI = 2'd1;
  localparam logic [1:0] MODE_MADD_AXI_NTT = 2'd2;

  // Bit positions of each stage in the per-stage start/done/flag vectors.
  typedef enum logic [1:0] {
    STG_AXI  = 2'd0,
    STG_NTT  = 2'd1,
    STG_MADD = 2'd2
  } stage_e;

  localparam int NUM_STAGES = 3;

  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      MODE_AXI_NTT_MADD: return MODE_NTT_MADD_AXI;
      MODE_NTT_MADD_AXI: return MODE_MADD_AXI_NTT;
      default:           return MODE_AXI_NTT_MADD;
    endcase
  endfunction

endpackage

// File: rtl/dp_stage_flag.sv
// ---------------------------------------------------------------------------
// dp_stage_flag
// Sticky "stage finished" flag. Set by a done pulse while enabled, held until
// cleared. Clear wins over set so a round always starts from a clean flag.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - clear the flag (start of a round)
//   i_en      - flag may be set (stage active and controller waiting)
//   i_done    - stage-complete pulse
//   o_flag    - registered sticky flag
// ---------------------------------------------------------------------------
module dp_stage_flag
  import dp_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_done,
  output logic o_flag
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_flag <= 1'b0;
    end else if (i_clr) begin
      o_flag <= 1'b0;
    end else if (i_en && i_done) begin
      o_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/dp_tpp_rotate_ctrl.sv
// ---------------------------------------------------------------------------
// dp_tpp_rotate_ctrl
// Round sequencer for a three-stage (AXI load, NTT, MADD) pipeline sharing a
// triple buffer. A job of N polyvecs runs N+2 rounds; in each round the
// active stages are started together, the controller waits for all of them
// to report done, then rotates the buffer with a one-cycle o_swap pulse.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   i_start, i_num_batch        - job request and polyvec count N
//   i_axi/ntt/madd_done         - stage-complete pulses
//   o_axi/ntt/madd_start        - stage-start pulses
//   o_swap                      - buffer rotate pulse (triple-buffer i_done)
//   o_mode                      - mirror of the buffer mode
//   o_busy, o_done, o_round     - status, job-complete pulse, round index
// ---------------------------------------------------------------------------
module dp_tpp_rotate_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_num_batch,
  input  logic                 i_axi_done,
  input  logic                 i_ntt_done,
  input  logic                 i_madd_done,
  output logic                 o_axi_start,
  output logic                 o_ntt_start,
  output logic                 o_madd_start,
  output logic                 o_swap,
  output logic [1:0]           o_mode,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_round
);

  // One extra bit so that N+2 rounds never wraps for the largest N.
  localparam int RW = CNT_WIDTH + 1;

  state_e                state_reg;
  logic [CNT_WIDTH-1:0]  n_reg;
  logic [RW-1:0]         r_reg;
  logic [NUM_STAGES-1:0] start_reg;

  logic [NUM_STAGES-1:0] done_vec;
  logic [NUM_STAGES-1:0] flag_vec;
  logic [NUM_STAGES-1:0] active_vec;
  logic [RW-1:0]         n_ext;
  logic [RW-1:0]         r_inc;
  logic [RW-1:0]         rounds_total;
  logic                  issue_st;
  logic                  wait_st;
  logic                  all_hit;

  // Which stages work in round r of an N-batch job:
  // AXI loads rounds 0..N-1, NTT runs one round behind, MADD two behind.
  function automatic logic [NUM_STAGES-1:0] stage_active(input logic [RW-1:0] r,
                                                         input logic [RW-1:0] n);
    logic [NUM_STAGES-1:0] a;
    a           = '0;
    a[STG_AXI]  = (r < n);
    a[STG_NTT]  = (r >= RW'(1)) && (r <= n);
    a[STG_MADD] = (r >= RW'(2)) && (r <= n + RW'(1));
    return a;
  endfunction

  assign n_ext        = {1'b0, n_reg};
  assign r_inc        = r_reg + RW'(1);
  assign rounds_total = n_ext + RW'(2);
  assign active_vec   = stage_active(r_reg, n_ext);
  assign issue_st     = (state_reg == ST_ISSUE);
  assign wait_st      = (state_reg == ST_WAIT);

  assign done_vec[STG_AXI]  = i_axi_done;
  assign done_vec[STG_NTT]  = i_ntt_done;
  assign done_vec[STG_MADD] = i_madd_done;

  // Done pulses arriving this cycle count together with earlier sticky flags,
  // so the swap fires in the cycle after the last required done.
  assign all_hit = ((active_vec & ~(flag_vec | done_vec)) == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_flag
      dp_stage_flag u_flag (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (issue_st),
        .i_en   (wait_st & active_vec[gi]),
        .i_done (done_vec[gi]),
        .o_flag (flag_vec[gi])
      );
    end
  endgenerate

  // Outputs are registered alongside the state so each pulse is high exactly
  // in the state it belongs to (starts in ISSUE, o_swap in SWAP). o_done is
  // produced when leaving FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      n_reg     <= '0;
      r_reg     <= '0;
      start_reg <= '0;
      o_swap    <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_mode    <= MODE_AXI_NTT_MADD;
    end else begin
      start_reg <= '0;
      o_swap    <= 1'b0;
      o_done    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            n_reg  <= i_num_batch;
            r_reg  <= '0;
            o_busy <= 1'b1;
            if (i_num_batch == '0) begin
              state_reg <= ST_FINISH;
            end else begin
              state_reg <= ST_ISSUE;
              start_reg <= stage_active('0, {1'b0, i_num_batch});
            end
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (all_hit) begin
            state_reg <= ST_SWAP;
            o_swap    <= 1'b1;
          end
        end
        ST_SWAP: begin
          // Mode and round advance on the same edge the buffer sees o_swap.
          r_reg  <= r_inc;
          o_mode <= next_mode(o_mode);
          if (r_inc == rounds_total) begin
            state_reg <= ST_FINISH;
          end else begin
            state_reg <= ST_ISSUE;
            start_reg <= stage_active(r_inc, n_ext);
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
          o_done    <= 1'b1;
          o_busy    <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_axi_start  = start_reg[STG_AXI];
  assign o_ntt_start  = start_reg[STG_NTT];
  assign o_madd_start = start_reg[STG_MADD];
  assign o_round      = r_reg[CNT_WIDTH-1:0];

endmodule
